// File: rtl/id_scoreboard_if.sv
// Decode-stage scoreboard bus: decoder request, writeback retire, and scoreboard status.
interface id_scoreboard_if;
  logic        id_valid;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        use1;
  logic        use2;
  logic        we3;
  logic [4:0]  wa3;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_wa3;
  logic        stall;
  logic        issue;
  logic [2:0]  inflight;
  logic [15:0] stall_cycles;
  logic        wb_err;

  modport master (
    output id_valid, ra1, ra2, use1, use2, we3, wa3, flush, wb_valid, wb_wa3,
    input  stall, issue, inflight, stall_cycles, wb_err
  );

  modport slave (
    input  id_valid, ra1, ra2, use1, use2, we3, wa3, flush, wb_valid, wb_wa3,
    output stall, issue, inflight, stall_cycles, wb_err
  );
endinterface

// File: rtl/id_scoreboard.sv
// Register-write scoreboard for the decode stage: tracks pending destination registers,
// stalls on RAW/WAW hazards or write capacity, and counts stall cycles.
module id_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input logic            clk,
  input logic            reset,
  id_scoreboard_if.slave bus
);

  localparam logic [2:0] MaxInflight = 3'(MAX_INFLIGHT);

  logic [31:0] pending_q, pending_d;
  logic [2:0]  inflight_q, inflight_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        wb_err_q, wb_err_d;

  logic hazard1, hazard2, waw, full;
  logic stall, issue;
  logic set_en, clr_en, wb_miss;

  // Hazards look only at registered pending state; a same-cycle writeback does not bypass.
  always_comb begin
    hazard1 = bus.use1 && (bus.ra1 != 5'd0) && pending_q[bus.ra1];
    hazard2 = bus.use2 && (bus.ra2 != 5'd0) && pending_q[bus.ra2];
    waw     = bus.we3 && (bus.wa3 != 5'd0) && pending_q[bus.wa3];
    full    = bus.we3 && (bus.wa3 != 5'd0) && (inflight_q == MaxInflight);
    stall   = bus.id_valid && !bus.flush && (hazard1 || hazard2 || waw || full);
    issue   = bus.id_valid && !bus.flush && !stall;
  end

  always_comb begin
    set_en  = issue && bus.we3 && (bus.wa3 != 5'd0);
    clr_en  = bus.wb_valid && (bus.wb_wa3 != 5'd0) && pending_q[bus.wb_wa3];
    wb_miss = bus.wb_valid && (bus.wb_wa3 != 5'd0) && !pending_q[bus.wb_wa3];

    pending_d = pending_q;
    if (clr_en) pending_d[bus.wb_wa3] = 1'b0;
    // Set after clear so a forced same-register set/clear leaves the bit set.
    if (set_en) pending_d[bus.wa3] = 1'b1;
    pending_d[0] = 1'b0;

    inflight_d = inflight_q;
    if (set_en && !clr_en && (inflight_q != MaxInflight)) begin
      inflight_d = inflight_q + 3'd1;
    end else if (clr_en && !set_en && (inflight_q != 3'd0)) begin
      inflight_d = inflight_q - 3'd1;
    end

    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;

    wb_err_d = wb_err_q || wb_miss;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q      <= '0;
      inflight_q     <= '0;
      stall_cycles_q <= '0;
      wb_err_q       <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      inflight_q     <= inflight_d;
      stall_cycles_q <= stall_cycles_d;
      wb_err_q       <= wb_err_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.issue        = issue;
  assign bus.inflight     = inflight_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.wb_err       = wb_err_q;

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-002 SHALL have id_valid input 1: the decode stage holds a valid instruction.
REQ-003 SHALL have ra1, ra2 inputs 5 each: source register addresses from the decoder.
REQ-004 SHALL have use1, use2 inputs 1 each: the instruction reads ra1 or ra2, respectively.
REQ-005 SHALL have we3 input 1 and wa3 input 5: the instruction writes register wa3.
REQ-006 SHALL have flush input 1: squash the instruction in decode; no issue occurs.
REQ-007 SHALL have wb_valid input 1 and wb_wa3 input 5: a writeback to the regfile retires a pending write this cycle.
REQ-008 SHALL have stall output 1: hold decode; combinational.
REQ-009 SHALL have issue output 1: the instruction leaves decode this cycle; combinational.
REQ-010 SHALL have inflight output 3: count of issued, unretired register writes.
REQ-011 SHALL have stall_cycles output 16: saturating count of stalled cycles.
REQ-012 SHALL have wb_err output 1: sticky flag for an unmatched writeback.
REQ-013 SHALL have parameter MAX_INFLIGHT, default 4, range 1..7: maximum outstanding writes.

Function
REQ-014 SHALL hold a 32-bit pending bitmap; bit 0 (x0) is never set.
REQ-015 SHALL compute hazard1 as use1 && ra1!=0 && pending[ra1]; hazard2 likewise for use2 and ra2.
REQ-016 SHALL compute waw as we3 && wa3!=0 && pending[wa3].
REQ-017 SHALL compute full as we3 && wa3!=0 && inflight==MAX_INFLIGHT.
REQ-018 SHALL drive stall = id_valid && !flush && (hazard1 || hazard2 || waw || full).
REQ-019 SHALL drive issue = id_valid && !flush && !stall.
REQ-020 SHALL use only registered pending state for hazard checks: a same-cycle writeback to a source register does not clear the hazard, and the earliest issue is the next cycle.
REQ-021 On issue with we3 && wa3!=0, SHALL set pending[wa3] and increment inflight at the clock edge.
REQ-022 On wb_valid && wb_wa3!=0 && pending[wb_wa3], SHALL clear pending[wb_wa3] and decrement inflight.
REQ-023 SHALL leave inflight unchanged on a simultaneous set and clear in one cycle; both bitmap updates apply.
REQ-024 For a set and clear on the same register in one cycle: waw guarantees it cannot be issued; if forced, set wins.
REQ-025 SHALL ignore wb_valid with wb_wa3==0 entirely.
REQ-026 On wb_valid with wb_wa3!=0 and pending[wb_wa3]==0, SHALL change no state and set wb_err.
REQ-027 SHALL keep wb_err at 1 until reset.
REQ-028 SHALL increment stall_cycles each cycle stall==1 and saturate at 16'hFFFF with no wrap.
REQ-029 SHALL not increment stall_cycles on flush cycles.
REQ-030 SHALL never let inflight exceed MAX_INFLIGHT or underflow below 0.
REQ-031 SHALL give flush no effect on the pending bitmap or inflight: already-issued writes still retire.

Reset
REQ-032 While reset==1 at a clock edge, SHALL clear pending, inflight, stall_cycles and wb_err to 0, overriding any same-cycle issue or writeback.
REQ-033 SHALL let stall and issue remain combinational during reset; state is cleared at the edge.
REQ-034 Reset mid-operation SHALL discard all outstanding writes; the first cycle after reset shows stall=0 for any source register.

Verification
REQ-035 SHALL cover RAW: issue we3=1, wa3=5; next cycle use1=1, ra1=5 -> stall=1, stall_cycles increments; cycle after wb_valid=1, wb_wa3=5 -> stall=0, issue=1.
REQ-036 SHALL cover same-cycle writeback: wb_wa3=5 in the same cycle as the dependent read -> stall=1 that cycle, issue=1 the next cycle.
REQ-037 SHALL cover capacity with MAX_INFLIGHT=4: issue writes to x1..x4 -> inflight=4; a write to x6 stalls; a retire of x2 concurrent with the stall -> next cycle issue=1, inflight=4.
REQ-038 SHALL cover x0 and errors: writes to x0 -> inflight stays 0, no stall; wb_wa3=9 with no pending entry -> wb_err=1, inflight unchanged.
REQ-039 SHALL cover flush and reset: flush during a hazard -> issue=0, stall=0; reset with inflight=3 -> all counters 0 next cycle.
REQ-040 SHALL cover saturation: hold stall for 70000 cycles -> stall_cycles=16'hFFFF.
